// File: rtl/demux_pkg.sv
// demux_pkg: shared sizes and types for the 1-to-8 buffered flit demultiplexer.
package demux_pkg;
    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;
    localparam int DEPTH   = 2;
    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [1:0]       cnt_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: 2-entry skid buffer holding the head flit and one spare for a single output.
module demux_slot
    import demux_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         full
);
    cnt_t         cnt_q, cnt_d;
    logic [N-1:0] head_q, head_d, tail_q, tail_d;
    logic         do_push, do_pop;

    assign full     = cnt_q == cnt_t'(DEPTH);
    assign valid    = cnt_q != 2'd0;
    assign data_out = head_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && valid;

    // A push goes straight to the head when the buffer is empty or the head leaves this cycle.
    always_comb begin
        cnt_d  = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
        head_d = (do_push && (cnt_q == 2'd0 || do_pop)) ? data_in :
                 (do_pop && cnt_q == 2'd2)              ? tail_q  : head_q;
        tail_d = (do_push && !do_pop && cnt_q == 2'd1)  ? data_in : tail_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/demux1_8_buf.sv
// demux1_8_buf: steers valid/ready flits to one of 8 independently drained 2-entry buffers.
module demux1_8_buf
    import demux_pkg::*;
#(
    parameter int N = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              i_data,
    input  sel_t                      i_sel,
    input  logic                      i_valid,
    output logic                      i_ready,
    output logic [NUM_OUT-1:0][N-1:0] o_data,
    output logic [NUM_OUT-1:0]        o_valid,
    input  logic [NUM_OUT-1:0]        o_ready
);
    logic [NUM_OUT-1:0] full, push;

    // Ready looks only at registered full flags, never at o_ready.
    assign i_ready = !reset && !full[i_sel];
    assign push    = (i_valid && i_ready) ? {{(NUM_OUT-1){1'b0}}, 1'b1} << i_sel : '0;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(.N(N)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .push     (push[k]),
            .pop      (o_ready[k]),
            .data_in  (i_data),
            .data_out (o_data[k]),
            .valid    (o_valid[k]),
            .full     (full[k])
        );
    end
endmodule

// File: tb/tb_demux1_8_buf.sv
// tb_demux1_8_buf: scoreboard bench; accepted flits are queued per output and checked as they drain.
module tb_demux1_8_buf;
    logic             clk = 0;
    logic             reset = 1;
    logic [63:0]      i_data = '0;
    logic [2:0]       i_sel = '0;
    logic             i_valid = 1;
    logic             i_ready;
    logic [7:0][63:0] o_data;
    logic [7:0]       o_valid;
    logic [7:0]       o_ready = '0;

    logic [63:0] sb [8][$];
    logic [7:0]  exp_v;
    int          n_vec = 0;
    int          n_err = 0;
    int          w;

    demux1_8_buf #(.N(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_sel   (i_sel),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the flit was accepted.
    task automatic send(input logic [63:0] d, input logic [2:0] s, output int waits);
        i_valid = 1; i_data = d; i_sel = s; waits = 0;
        @(negedge clk);
        while (!i_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!i_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        i_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) exp_v[k] = sb[k].size() != 0;
            chk("o_valid", 64'(o_valid), 64'(exp_v));
            for (int k = 0; k < 8; k++)
                if (o_valid[k] && o_ready[k]) begin
                    if (sb[k].size() == 0) chk($sformatf("extra%0d", k), 64'd1, 64'd0);
                    else chk($sformatf("out%0d", k), o_data[k], sb[k].pop_front());
                end
            if (i_valid && i_ready) sb[i_sel].push_back(i_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(i_ready), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(|o_data), 64'd0);
        i_valid = 0;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rel_ready", 64'(i_ready), 64'd1);

        o_ready = 8'hFF;
        @(posedge clk); #1;
        send(64'hA5, 3'd5, w);
        @(negedge clk);
        chk("single_v", 64'(o_valid), 64'h20);
        chk("single_d", o_data[5], 64'hA5);
        @(negedge clk);
        chk("single_gone", 64'(o_valid), 64'h00);

        @(posedge clk); #1;
        o_ready = 8'hFB;
        send(64'h1, 3'd2, w);
        send(64'h2, 3'd2, w);
        i_valid = 1; i_data = 64'h3; i_sel = 3'd2;
        @(negedge clk);
        chk("bp_ready", 64'(i_ready), 64'd0);
        chk("bp_hold", o_data[2], 64'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_hold2", o_data[2], 64'h1);
        @(posedge clk); #1 o_ready = 8'hFF;
        @(negedge clk);
        chk("bp_pre_pop", 64'(i_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_post_pop", 64'(i_ready), 64'd1);
        chk("bp_head2", o_data[2], 64'h2);
        @(posedge clk); #1 i_valid = 0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            send(64'h7000 + 64'(i), 3'd7, w);
            chk("stream_rdy", 64'(w), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        o_ready = 8'hFE;
        send(64'h10, 3'd0, w);
        send(64'h11, 3'd0, w);
        i_valid = 1; i_data = 64'h12; i_sel = 3'd0;
        @(negedge clk);
        chk("iso_rdy0", 64'(i_ready), 64'd0);
        @(posedge clk); #1;
        i_sel = 3'd3; i_data = 64'h13;
        @(negedge clk);
        chk("iso_rdy3", 64'(i_ready), 64'd1);
        @(posedge clk); #1 i_valid = 0;
        @(negedge clk);
        chk("iso_v", 64'(o_valid), 64'h09);
        chk("iso_d3", o_data[3], 64'h13);
        @(posedge clk); #1 o_ready = 8'hFF;
        repeat (4) @(posedge clk);
        #1;

        o_ready = 8'h00;
        send(64'h21, 3'd1, w);
        send(64'h22, 3'd1, w);
        send(64'h23, 3'd4, w);
        send(64'h24, 3'd4, w);
        chk("pre_rst_v", 64'(o_valid), 64'h12);
        #1 reset = 1;
        for (int k = 0; k < 8; k++) sb[k].delete();
        #1;
        chk("mid_rst_v", 64'(o_valid), 64'h00);
        chk("mid_rst_rdy", 64'(i_ready), 64'd0);
        @(posedge clk); #1;
        reset = 0; o_ready = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_v", 64'(o_valid), 64'h00);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) chk("sb_empty", 64'(sb[k].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
